// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of the single sdram controller port: the CPU bridge
// (reads and writes) and the sample DMA writer. At most one transaction is in flight downstream.
module sdram_arbiter #(
   parameter int AW    = 24,
   parameter int DW    = 16,
   parameter int BURST = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,

   input  logic [AW-1:0] cpu_awaddr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_wvalid,
   output logic          cpu_wready,
   input  logic [AW-1:0] cpu_araddr,
   input  logic          cpu_arvalid,
   output logic          cpu_arready,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,

   input  logic [AW-1:0] dma_awaddr,
   input  logic [DW-1:0] dma_wdata,
   input  logic          dma_wvalid,
   output logic          dma_wready,

   output logic [AW-1:0] m_awaddr,
   output logic [DW-1:0] m_wdata,
   output logic          m_wvalid,
   input  logic          m_wready,
   output logic [AW-1:0] m_araddr,
   output logic          m_arvalid,
   input  logic          m_arready,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_rvalid,

   output logic          grant_dma,
   output logic [15:0]   dma_stall,
   input  logic          stall_clr
);

   typedef enum logic [2:0] {
      IDLE,
      WR_CPU,
      WR_DMA,
      RD_ADDR,
      RD_WAIT
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(BURST);

   state_t      state_reg;
   state_t      state_next;
   logic [3:0]  run_cnt_reg;
   logic [3:0]  run_cnt_next;
   logic [15:0] stall_reg;
   logic [15:0] stall_next;
   logic        cpu_req;
   logic        dma_done;

   assign cpu_req  = cpu_wvalid | cpu_arvalid;
   assign dma_done = (state_reg == WR_DMA) && m_wready;

   // Read data is passed straight through: only the CPU ever issues reads.
   assign cpu_rdata  = m_rdata;
   assign cpu_rvalid = m_rvalid;
   assign dma_stall  = stall_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         run_cnt_reg <= '0;
         stall_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         run_cnt_reg <= run_cnt_next;
         stall_reg   <= stall_next;
      end
   end

   always_comb begin
      stall_next = stall_reg;
      if (stall_clr) begin
         stall_next = '0;
      end else if (dma_wvalid && !dma_done && (stall_reg != 16'hFFFF)) begin
         stall_next = stall_reg + 16'd1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      run_cnt_next = run_cnt_reg;
      m_awaddr     = '0;
      m_wdata      = '0;
      m_wvalid     = 1'b0;
      m_araddr     = '0;
      m_arvalid    = 1'b0;
      cpu_wready   = 1'b0;
      cpu_arready  = 1'b0;
      dma_wready   = 1'b0;
      grant_dma    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (enable) begin
               // DMA wins unless the CPU has already sat through a full burst of DMA grants.
               if (dma_wvalid && !(cpu_req && (run_cnt_reg >= BURST_MAX))) begin
                  state_next   = WR_DMA;
                  run_cnt_next = (run_cnt_reg >= BURST_MAX) ? BURST_MAX : run_cnt_reg + 4'd1;
               end else if (cpu_wvalid) begin
                  state_next   = WR_CPU;
                  run_cnt_next = '0;
               end else if (cpu_arvalid) begin
                  state_next   = RD_ADDR;
                  run_cnt_next = '0;
               end
            end
         end

         WR_CPU: begin
            m_awaddr   = cpu_awaddr;
            m_wdata    = cpu_wdata;
            m_wvalid   = 1'b1;
            cpu_wready = m_wready;
            if (m_wready) begin
               state_next = IDLE;
            end
         end

         WR_DMA: begin
            m_awaddr   = dma_awaddr;
            m_wdata    = dma_wdata;
            m_wvalid   = 1'b1;
            dma_wready = m_wready;
            grant_dma  = 1'b1;
            if (m_wready) begin
               state_next = IDLE;
            end
         end

         RD_ADDR: begin
            m_araddr    = cpu_araddr;
            m_arvalid   = 1'b1;
            cpu_arready = m_arready;
            if (m_arready) begin
               state_next = RD_WAIT;
            end
         end

         RD_WAIT: begin
            if (m_rvalid) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
